// File: rtl/bean_eat_ctrl_pkg.sv
// Shared constants for the bean map: playfield geometry, sprite size,
// FSM state encodings and the row/column to flat map index helper.
package bean_eat_ctrl_pkg;

  localparam int COLS       = 40;
  localparam int ROWS       = 30;
  localparam int CELL_SHIFT = 4;
  localparam int PAC_SIZE   = 32;
  localparam int SCORE_W    = 11;
  localparam int MAP_BITS   = COLS * ROWS;
  localparam int IDX_W      = 11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CALC  = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_COUNT = 3'd4;

  // Flat map index of a cell; map is stored row-major.
  function automatic logic [IDX_W-1:0] cell_index(input logic [4:0] row,
                                                  input logic [5:0] col);
    return IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
  endfunction

endpackage

// File: rtl/bean_eat_ctrl_cell_window.sv
// Converts the sprite's top-left pixel position into the inclusive range of
// map cells it overlaps, clamped to the playfield so the scan never leaves it.
module bean_cell_window
  import bean_eat_ctrl_pkg::*;
(
  input  logic [9:0] pac_x,
  input  logic [8:0] pac_y,
  output logic [5:0] c0,
  output logic [5:0] c1,
  output logic [4:0] r0,
  output logic [4:0] r1
);

  // Far-edge sums are one bit wider so a sprite near the right/bottom edge
  // does not wrap back to column/row 0.
  logic [10:0] x_end;
  logic [9:0]  y_end;
  logic [10:0] c0_raw;
  logic [10:0] c1_raw;
  logic [9:0]  r0_raw;
  logic [9:0]  r1_raw;

  // Pixel-to-cell conversion with clamping to the last column/row.
  always_comb begin
    x_end  = {1'b0, pac_x} + 11'(PAC_SIZE - 1);
    y_end  = {1'b0, pac_y} + 10'(PAC_SIZE - 1);
    c0_raw = {1'b0, pac_x} >> CELL_SHIFT;
    c1_raw = x_end >> CELL_SHIFT;
    r0_raw = {1'b0, pac_y} >> CELL_SHIFT;
    r1_raw = y_end >> CELL_SHIFT;
    c0 = (c0_raw > 11'(COLS - 1)) ? 6'(COLS - 1) : c0_raw[5:0];
    c1 = (c1_raw > 11'(COLS - 1)) ? 6'(COLS - 1) : c1_raw[5:0];
    r0 = (r0_raw > 10'(ROWS - 1)) ? 5'(ROWS - 1) : r0_raw[4:0];
    r1 = (r1_raw > 10'(ROWS - 1)) ? 5'(ROWS - 1) : r1_raw[4:0];
  end

endmodule

// File: rtl/bean_eat_ctrl.sv
// Bean map owner: scans the cells under the pacman sprite one per cycle,
// clears eaten beans, keeps score and beans_left, reloads/recounts the map
// per level and serves registered single-cell reads for the renderer.
module bean_eat_ctrl
  import bean_eat_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MAP_BITS-1:0]   init_map,
  input  logic                  load_map,
  input  logic                  start,
  input  logic [9:0]            pac_x,
  input  logic [8:0]            pac_y,
  input  logic [5:0]            rd_col,
  input  logic [4:0]            rd_row,
  output logic                  rd_bean,
  output logic                  busy,
  output logic                  done,
  output logic [SCORE_W-1:0]    score,
  output logic [SCORE_W-1:0]    beans_left,
  output logic                  all_eaten
);

  logic [2:0]          state_reg, state_next;
  logic [MAP_BITS-1:0] map_reg, map_next;
  logic [MAP_BITS-1:0] clr_mask;
  logic [9:0]          px_reg;
  logic [8:0]          py_reg;
  logic [5:0]          c_reg, c0_reg, c1_reg;
  logic [4:0]          r_reg, r1_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [SCORE_W-1:0]  score_reg, beans_left_reg;
  logic                rd_bean_reg;
  logic [5:0]          w_c0, w_c1;
  logic [4:0]          w_r0, w_r1;
  logic [IDX_W-1:0]    scan_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic                scan_last;

  bean_cell_window u_window (
    .pac_x (px_reg),
    .pac_y (py_reg),
    .c0    (w_c0),
    .c1    (w_c1),
    .r0    (w_r0),
    .r1    (w_r1)
  );

  assign scan_idx  = cell_index(r_reg, c_reg);
  assign rd_idx    = cell_index(rd_row, rd_col);
  assign scan_last = (r_reg == r1_reg) && (c_reg == c1_reg);

  // One-hot clear strobe for the cell under the scan pointer; clearing an
  // already-empty cell is harmless, so every SCAN cycle strobes.
  genvar gi;
  generate
    for (gi = 0; gi < MAP_BITS; gi++) begin : g_clr
      assign clr_mask[gi] = (state_reg == ST_SCAN) && (scan_idx == IDX_W'(gi));
    end
  endgenerate

  // Map update: a level load overrides any clear in the same cycle.
  always_comb begin
    map_next = map_reg & ~clr_mask;
    if (load_map) map_next = init_map;
  end

  // Next-state logic; load_map preempts every state and drops a coincident start.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_CALC;
      ST_CALC:  state_next = ST_SCAN;
      ST_SCAN:  if (scan_last) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      ST_COUNT: if (idx_reg == IDX_W'(MAP_BITS - 1)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (load_map) state_next = ST_COUNT;
  end

  // State, map, scan pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      map_reg        <= '0;
      px_reg         <= '0;
      py_reg         <= '0;
      c_reg          <= '0;
      c0_reg         <= '0;
      c1_reg         <= '0;
      r_reg          <= '0;
      r1_reg         <= '0;
      idx_reg        <= '0;
      score_reg      <= '0;
      beans_left_reg <= '0;
    end else begin
      state_reg <= state_next;
      map_reg   <= map_next;
      if (load_map) begin
        idx_reg        <= '0;
        beans_left_reg <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              px_reg <= pac_x;
              py_reg <= pac_y;
            end
          end
          ST_CALC: begin
            c0_reg <= w_c0;
            c1_reg <= w_c1;
            r1_reg <= w_r1;
            c_reg  <= w_c0;
            r_reg  <= w_r0;
          end
          ST_SCAN: begin
            if (map_reg[scan_idx]) begin
              if (score_reg != '1) score_reg <= score_reg + 1'b1;
              if (beans_left_reg != '0) beans_left_reg <= beans_left_reg - 1'b1;
            end
            if (c_reg == c1_reg) begin
              c_reg <= c0_reg;
              r_reg <= r_reg + 1'b1;
            end else begin
              c_reg <= c_reg + 1'b1;
            end
          end
          ST_COUNT: begin
            beans_left_reg <= beans_left_reg + SCORE_W'(map_reg[idx_reg]);
            idx_reg        <= idx_reg + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Renderer read port: registered, reads the pre-update map, 0 off-grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bean_reg <= 1'b0;
    end else if ((rd_row < 5'(ROWS)) && (rd_col < 6'(COLS))) begin
      rd_bean_reg <= map_reg[rd_idx];
    end else begin
      rd_bean_reg <= 1'b0;
    end
  end

  assign rd_bean    = rd_bean_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign score      = score_reg;
  assign beans_left = beans_left_reg;
  assign all_eaten  = (beans_left_reg == '0) && (state_reg == ST_IDLE);

endmodule

// File: tb/tb_bean_eat_ctrl.sv
// Directed bench for bean_eat_ctrl: reset values, map load/recount, aligned,
// unaligned and clamped scans, renderer reads and overlapping events.
module tb_bean_eat_ctrl;

  logic          clk;
  logic          rst_n;
  logic [1199:0] init_map;
  logic          load_map;
  logic          start;
  logic [9:0]    pac_x;
  logic [8:0]    pac_y;
  logic [5:0]    rd_col;
  logic [4:0]    rd_row;
  logic          rd_bean;
  logic          busy;
  logic          done;
  logic [10:0]   score;
  logic [10:0]   beans_left;
  logic          all_eaten;

  int checks = 0;
  int errors = 0;

  bean_eat_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_map   (init_map),
    .load_map   (load_map),
    .start      (start),
    .pac_x      (pac_x),
    .pac_y      (pac_y),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_bean    (rd_bean),
    .busy       (busy),
    .done       (done),
    .score      (score),
    .beans_left (beans_left),
    .all_eaten  (all_eaten)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Start a scan; measure the cycle of done counting the start cycle as 0.
  task automatic do_scan(input string tag, input logic [9:0] x, input logic [8:0] y,
                         input int exp_lat, input bit inject_start);
    int cnt;
    @(negedge clk);
    pac_x = x; pac_y = y; start = 1'b1;
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) start = 1'b0;
      if (inject_start && cnt == 3) begin start = 1'b1; pac_x = 10'd200; pac_y = 9'd200; end
      if (inject_start && cnt == 4) start = 1'b0;
      if (done) break;
    end
    chk({tag, "_lat"}, cnt, exp_lat);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_1cyc"}, done, 0);
  endtask

  // Load a map and return the number of cycles busy stays high.
  task automatic load_count(input logic [1199:0] m, input bit with_start, output int n);
    @(negedge clk);
    init_map = m; load_map = 1'b1; start = with_start; pac_x = '0; pac_y = '0;
    @(negedge clk);
    load_map = 1'b0; start = 1'b0;
    n = 0;
    while (busy && n < 1300) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] r, input logic [5:0] c, input int exp);
    @(negedge clk);
    rd_row = r; rd_col = c;
    @(negedge clk);
    chk(tag, rd_bean, exp);
  endtask

  initial begin
    int n;
    int dn;
    logic [1199:0] m;
    rst_n = 1'b0; init_map = '0; load_map = 1'b0; start = 1'b0;
    pac_x = '0; pac_y = '0; rd_col = '0; rd_row = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_score", score, 0);
    chk("rst_beans", beans_left, 0);
    chk("rst_all_eaten", all_eaten, 1);
    chk("rst_rd_bean", rd_bean, 0);

    // Full map load and recount.
    m = '1;
    load_count(m, 1'b0, n);
    chk("load_busy_cycles", n, 1200);
    chk("load_beans", beans_left, 1200);
    chk("load_all_eaten", all_eaten, 0);

    // Aligned 2x2 scan.
    do_scan("aligned", 10'd32, 9'd48, 6, 1'b0);
    chk("aligned_score", score, 4);
    chk("aligned_beans", beans_left, 1196);
    rd_chk("rd_r3c2_eaten", 5'd3, 6'd2, 0);
    rd_chk("rd_r2c2_full", 5'd2, 6'd2, 1);

    // Unaligned 3x3 scan overlapping the eaten block, then a repeat.
    do_scan("unal", 10'd40, 9'd40, 11, 1'b0);
    chk("unal_score", score, 9);
    chk("unal_beans", beans_left, 1191);
    do_scan("repeat", 10'd40, 9'd40, 11, 1'b0);
    chk("repeat_score", score, 9);

    // Bottom-right corner, window clamped to a single cell.
    do_scan("clamp", 10'd630, 9'd470, 3, 1'b0);
    chk("clamp_score", score, 10);
    chk("clamp_beans", beans_left, 1190);
    rd_chk("rd_r29c39", 5'd29, 6'd39, 0);
    rd_chk("rd_r29c38", 5'd29, 6'd38, 1);
    rd_chk("rd_r28c39", 5'd28, 6'd39, 1);
    rd_chk("rd_col_oor", 5'd0, 6'd40, 0);
    rd_chk("rd_row_oor", 5'd30, 6'd0, 0);

    // Start during SCAN is dropped.
    do_scan("inj", 10'd0, 9'd0, 6, 1'b1);
    chk("inj_busy_after", busy, 0);
    @(negedge clk);
    chk("inj_busy_after2", busy, 0);
    chk("inj_score", score, 14);
    chk("inj_beans", beans_left, 1186);

    // load_map during SCAN aborts it: first cell eaten, no done, recount.
    m = '0; m[0] = 1'b1; m[45] = 1'b1;
    @(negedge clk);
    pac_x = 10'd64; pac_y = 9'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    init_map = m; load_map = 1'b1;
    @(negedge clk);
    load_map = 1'b0;
    n = 0; dn = 0;
    while (busy && n < 1300) begin
      if (done) dn++;
      n++;
      @(negedge clk);
    end
    chk("abort_busy_cycles", n, 1200);
    chk("abort_no_done", dn, 0);
    chk("abort_score", score, 15);
    chk("abort_beans", beans_left, 2);

    // Eat the two remaining beans; all_eaten only once back in IDLE.
    do_scan("last1", 10'd0, 9'd0, 6, 1'b0);
    chk("last1_beans", beans_left, 1);
    chk("last1_all_eaten", all_eaten, 0);
    @(negedge clk);
    pac_x = 10'd80; pac_y = 9'd0; start = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (done) break;
    end
    chk("last2_lat", n, 6);
    chk("last2_all_eaten_in_done", all_eaten, 0);
    @(negedge clk);
    chk("last2_all_eaten_idle", all_eaten, 1);
    chk("last2_score", score, 17);

    // load_map and start together: start dropped.
    m = '1;
    load_count(m, 1'b1, n);
    chk("ldst_busy_cycles", n, 1200);
    chk("ldst_busy_after", busy, 0);
    chk("ldst_score", score, 17);
    chk("ldst_beans", beans_left, 1200);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    pac_x = 10'd0; pac_y = 9'd0; start = 1'b1; rd_row = 5'd5; rd_col = 6'd5;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_rd_bean", rd_bean, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_score", score, 0);
    chk("midrst_beans", beans_left, 0);
    chk("midrst_all_eaten", all_eaten, 1);
    chk("midrst_rd_bean", rd_bean, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_r0c0", 5'd0, 6'd0, 0);
    rd_chk("post_rst_r5c5", 5'd5, 6'd5, 0);
    rd_chk("post_rst_r29c39", 5'd29, 6'd39, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
